rst_sequencer: RTL and testbench
================================

# rst_sequencer

Reset generator for the clocked logic under test: turns a raw asynchronous reset (and a software reset request) into a set of reset outputs. Each output asserts asynchronously and deasserts synchronously, after a synchronizer delay and a programmable hold time. The outputs are released one at a time in a staggered order. It drives the async, active-high reset pins of downstream async-reset flip-flops, so they never see a reset release unaligned to `clk`.

## Interface
Parameters:
- `SYNC_STAGES`, default 2: synchronizer depth; must be ≥ 2.
- `HOLD_CYCLES`, default 8: cycles outputs stay asserted after the synchronizer clears; must be ≥ 1.
- `NUM_OUT`, default 4: number of reset outputs; must be ≥ 1.
- `STAGGER`, default 2: cycles between successive output releases; must be ≥ 1.

Ports:
- `clk`, in, 1: clock.
- `arst`, in, 1: reset. Asynchronous, active-high. Clock is `clk`.
- `sw_rst_req`, in, 1: synchronous software reset request, level-sampled.
- `sw_rst_ack`, out, 1: one-cycle pulse, high when a request is accepted.
- `rst_out`, out, `NUM_OUT`: reset outputs, active-high; bit 0 is released first.
- `rst_done`, out, 1: high when all outputs are released.

## Operation
- **While `arst` is high:** `rst_out` = all ones, `rst_done` = 0, `sw_rst_ack` = 0, state = ASSERT, synchronizer flops = 1, counter = 0. All of these are forced asynchronously and take effect immediately, not at a clock edge.
- **FSM states:** ASSERT, HOLD, RELEASE, RUN.
- **ASSERT:** waits for the synchronized reset to drop. That happens at edge `SYNC_STAGES`, counting the first posedge with `arst` low as edge 1. On that edge the counter loads `HOLD_CYCLES-1` and the FSM moves to HOLD.
- **HOLD:** decrements the counter each edge. At 0 it clears `rst_out[0]`, loads `STAGGER-1`, sets index = 1 and moves to RELEASE.
  - If `NUM_OUT` = 1, HOLD goes straight to RUN and sets `rst_done` on that same edge.
- **RELEASE:** decrements the counter each edge. At 0 it clears `rst_out[index]` and increments index. When the last bit clears, it sets `rst_done` on that same edge and moves to RUN.
- **RUN:** an edge that samples `sw_rst_req` = 1 does all of the following:
  - sets all `rst_out` bits;
  - clears `rst_done`;
  - pulses `sw_rst_ack` for one cycle;
  - loads `HOLD_CYCLES-1` and enters HOLD.
  
  The synchronizer is not involved in a software reset.
- **`sw_rst_req` outside RUN:** ignored, with no ack. A request held high across return to RUN is accepted again on the first RUN edge.
- **`arst` asserted at any point:** the whole sequence restarts from ASSERT, including mid-HOLD, mid-RELEASE and the cycle of a `sw_rst_req`. A one-cycle glitch restarts it just the same.
- **Ordering invariant:** `rst_out[i]` is never released before `rst_out[i-1]`. `rst_out` bits change only on `clk` edges, except for async assertion by `arst`.
- **Counter width:** `$clog2(max(HOLD_CYCLES, STAGGER))+1` bits. Index width: `$clog2(NUM_OUT)+1` bits.

## Timing
- **Power-on:** with H = `SYNC_STAGES + HOLD_CYCLES`, `rst_out[i]` falls at edge H + i·`STAGGER`. `rst_done` rises at edge H + (`NUM_OUT`−1)·`STAGGER`.
- **Defaults:** edges 10, 12, 14, 16; `rst_done` at 16.
- **Software reset:** if the request is sampled at edge 0, `rst_out` goes all ones and `sw_rst_ack` = 1 after edge 0. `sw_rst_ack` returns to 0 after edge 1. `rst_out[0]` falls at edge `HOLD_CYCLES`, with later bits following at `STAGGER` spacing.
- **Outputs are registered:** no combinational path from `sw_rst_req` to any output.

## Structure
- Package `rst_seq_pkg` holds:
  - the state enum: ASSERT, HOLD, RELEASE, RUN;
  - a `max` helper function used to compute the counter width.
- Sub-module `rst_sync`: a `SYNC_STAGES`-deep flop chain, async-set by `arst`, shifting in 0. Its output is the synchronized reset.
- Top level holds the FSM, counter, index and output registers.
- Parameter legality is checked with elaboration-time `$error`.

## Test plan
- **Power-on, defaults:** `arst` high 3 cycles then low. `rst_out` = 4'b1111 until edge 10, then 4'b1110 @10, 4'b1100 @12, 4'b1000 @14, 4'b0000 @16. `rst_done` = 1 from edge 16.
- **`arst` mid-RELEASE:** assert `arst` between edges 12 and 13. `rst_out` = 4'b1111 and `rst_done` = 0 immediately, without waiting for an edge. After release, the full 10/12/14/16 schedule repeats, relative to the new release.
- **Software reset in RUN:** 1-cycle `sw_rst_req`. `sw_rst_ack` is a 1-cycle pulse, `rst_out` = 4'b1111 next cycle, `rst_out[0]` falls 8 edges after the request edge, and `rst_done` rises 14 edges after it.
- **Request during HOLD:** hold `sw_rst_req` high for 3 cycles in HOLD. No ack and the schedule is unchanged. Hold it high across entry to RUN: accepted on the first RUN edge.
- **`arst` glitch:** a 1-cycle `arst` pulse in RUN. Outputs go to 4'b1111 asynchronously and the full power-on schedule restarts.
- **Edge parameters:** `NUM_OUT`=1, `HOLD_CYCLES`=1, `SYNC_STAGES`=3. `rst_out` falls at edge 4, with `rst_done` rising the same edge.

Source files
------------

// File: rtl/rst_seq_pkg.sv
// Shared types and helpers for the reset sequencer.
package rst_seq_pkg;

  typedef enum logic [1:0] {
    ASSERT,
    HOLD,
    RELEASE,
    RUN
  } state_t;

  function automatic int max(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/rst_sync.sv
// Reset synchronizer: async-set flop chain that shifts in 0 on each clk edge.
module rst_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic arst,
  output logic sync_rst,
  output logic sync_rst_next
);

  logic [SYNC_STAGES-1:0] chain;

  // Set the whole chain asynchronously; release ripples through one stage per edge.
  always_ff @(posedge clk or posedge arst) begin
    if (arst) chain <= '1;
    else      chain <= {chain[SYNC_STAGES-2:0], 1'b0};
  end

  assign sync_rst      = chain[SYNC_STAGES-1];
  // Value the last stage captures on the coming edge.
  assign sync_rst_next = chain[SYNC_STAGES-2];

endmodule

// File: rtl/rst_sequencer.sv
// Reset sequencer: async-assert / sync-release of NUM_OUT staggered resets,
// with a software reset request accepted only once the sequence has completed.
module rst_sequencer
  import rst_seq_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int HOLD_CYCLES = 8,
  parameter int NUM_OUT     = 4,
  parameter int STAGGER     = 2
) (
  input  logic               clk,
  input  logic               arst,
  input  logic               sw_rst_req,
  output logic               sw_rst_ack,
  output logic [NUM_OUT-1:0] rst_out,
  output logic               rst_done
);

  localparam int CNT_W = $clog2(max(HOLD_CYCLES, STAGGER)) + 1;
  localparam int IDX_W = $clog2(NUM_OUT) + 1;

  localparam logic [CNT_W-1:0] HOLD_LOAD = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] STAG_LOAD = CNT_W'(STAGGER - 1);
  localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(NUM_OUT - 1);

  if (SYNC_STAGES < 2) begin : g_chk_sync
    $error("rst_sequencer: SYNC_STAGES must be >= 2");
  end
  if (HOLD_CYCLES < 1) begin : g_chk_hold
    $error("rst_sequencer: HOLD_CYCLES must be >= 1");
  end
  if (NUM_OUT < 1) begin : g_chk_num
    $error("rst_sequencer: NUM_OUT must be >= 1");
  end
  if (STAGGER < 1) begin : g_chk_stag
    $error("rst_sequencer: STAGGER must be >= 1");
  end

  state_t             state, state_next;
  logic [CNT_W-1:0]   cnt, cnt_next;
  logic [IDX_W-1:0]   idx, idx_next;
  logic [NUM_OUT-1:0] rst_out_next;
  logic               done_next;
  logic               ack_next;
  logic               sync_rst;
  logic               sync_rst_next;
  logic               cnt_zero;
  logic               last_bit;
  logic               sync_falling;

  rst_sync #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_sync (
    .clk          (clk),
    .arst         (arst),
    .sync_rst     (sync_rst),
    .sync_rst_next(sync_rst_next)
  );

  assign cnt_zero = (cnt == '0);
  assign last_bit = (idx == LAST_IDX);
  // Acting on the edge where the chain's last stage clears lets HOLD start on
  // edge SYNC_STAGES rather than one edge later.
  assign sync_falling = sync_rst && !sync_rst_next;

  // State, counter, index and all outputs; arst forces the reset values at once.
  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      state      <= ASSERT;
      cnt        <= '0;
      idx        <= '0;
      rst_out    <= '1;
      rst_done   <= 1'b0;
      sw_rst_ack <= 1'b0;
    end else begin
      state      <= state_next;
      cnt        <= cnt_next;
      idx        <= idx_next;
      rst_out    <= rst_out_next;
      rst_done   <= done_next;
      sw_rst_ack <= ack_next;
    end
  end

  // Next-state selection.
  always_comb begin
    state_next = state;
    unique case (state)
      ASSERT:  if (sync_falling) state_next = HOLD;
      HOLD:    if (cnt_zero) state_next = (NUM_OUT == 1) ? RUN : RELEASE;
      RELEASE: if (cnt_zero && last_bit) state_next = RUN;
      RUN:     if (sw_rst_req) state_next = HOLD;
      default: state_next = ASSERT;
    endcase
  end

  // Next values of counter, index and registered outputs.
  always_comb begin
    cnt_next     = cnt;
    idx_next     = idx;
    rst_out_next = rst_out;
    done_next    = rst_done;
    ack_next     = 1'b0;
    unique case (state)
      ASSERT: begin
        if (sync_falling) cnt_next = HOLD_LOAD;
      end
      HOLD: begin
        if (cnt_zero) begin
          rst_out_next[0] = 1'b0;
          if (NUM_OUT == 1) begin
            done_next = 1'b1;
          end else begin
            cnt_next = STAG_LOAD;
            idx_next = IDX_W'(1);
          end
        end else begin
          cnt_next = cnt - 1'b1;
        end
      end
      RELEASE: begin
        if (cnt_zero) begin
          for (int unsigned i = 0; i < NUM_OUT; i++) begin
            if (idx == IDX_W'(i)) rst_out_next[i] = 1'b0;
          end
          if (last_bit) begin
            done_next = 1'b1;
          end else begin
            idx_next = idx + 1'b1;
            cnt_next = STAG_LOAD;
          end
        end else begin
          cnt_next = cnt - 1'b1;
        end
      end
      RUN: begin
        if (sw_rst_req) begin
          rst_out_next = '1;
          done_next    = 1'b0;
          ack_next     = 1'b1;
          cnt_next     = HOLD_LOAD;
        end
      end
      default: begin
        rst_out_next = '1;
        done_next    = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_rst_sequencer.sv
// Self-checking bench for rst_sequencer: default configuration plus a
// NUM_OUT=1 / HOLD_CYCLES=1 / SYNC_STAGES=3 instance.
module tb_rst_sequencer;

  logic       clk = 1'b0;
  logic       arst;
  logic       sw_rst_req;
  logic       sw_rst_ack;
  logic [3:0] rst_out;
  logic       rst_done;

  logic       arst2;
  logic       req2;
  logic       ack2;
  logic [0:0] out2;
  logic       done2;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  rst_sequencer #(
    .SYNC_STAGES(2),
    .HOLD_CYCLES(8),
    .NUM_OUT    (4),
    .STAGGER    (2)
  ) u_dut (
    .clk       (clk),
    .arst      (arst),
    .sw_rst_req(sw_rst_req),
    .sw_rst_ack(sw_rst_ack),
    .rst_out   (rst_out),
    .rst_done  (rst_done)
  );

  rst_sequencer #(
    .SYNC_STAGES(3),
    .HOLD_CYCLES(1),
    .NUM_OUT    (1),
    .STAGGER    (2)
  ) u_edge (
    .clk       (clk),
    .arst      (arst2),
    .sw_rst_req(req2),
    .sw_rst_ack(ack2),
    .rst_out   (out2),
    .rst_done  (done2)
  );

  typedef struct {
    logic       arst;
    logic       req;
    logic [3:0] out;
    logic       done;
    logic       ack;
  } vec_t;

  vec_t tbl[20];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic chk_all(input string name, input logic [3:0] eo, input logic ed, input logic ea);
    chk({name, "_out"},  32'(rst_out),    32'(eo));
    chk({name, "_done"}, 32'(rst_done),   32'(ed));
    chk({name, "_ack"},  32'(sw_rst_ack), 32'(ea));
  endtask

  // Release schedule: bit i clears at edge base + 2*i, done with the last bit.
  function automatic logic [3:0] exp_out(input int k, input int base);
    logic [3:0] r;
    r = '1;
    for (int i = 0; i < 4; i++) if (k >= base + 2 * i) r[i] = 1'b0;
    return r;
  endfunction

  task automatic run_sched(input string name, input int base, input int k_from, input int k_to);
    for (int k = k_from; k <= k_to; k++) begin
      tick();
      chk_all($sformatf("%s_e%0d", name, k), exp_out(k, base), (k >= base + 6), 1'b0);
    end
  endtask

  initial begin
    arst       = 1'b1;
    sw_rst_req = 1'b0;
    arst2      = 1'b1;
    req2       = 1'b0;

    // Power-on vectors: three cycles of arst, then edges 1..17.
    tbl[0]  = '{1'b1, 1'b0, 4'hF, 1'b0, 1'b0};
    tbl[1]  = '{1'b1, 1'b0, 4'hF, 1'b0, 1'b0};
    tbl[2]  = '{1'b1, 1'b0, 4'hF, 1'b0, 1'b0};
    tbl[3]  = '{1'b0, 1'b0, 4'hF, 1'b0, 1'b0};
    tbl[4]  = '{1'b0, 1'b0, 4'hF, 1'b0, 1'b0};
    tbl[5]  = '{1'b0, 1'b0, 4'hF, 1'b0, 1'b0};
    tbl[6]  = '{1'b0, 1'b0, 4'hF, 1'b0, 1'b0};
    tbl[7]  = '{1'b0, 1'b0, 4'hF, 1'b0, 1'b0};
    tbl[8]  = '{1'b0, 1'b0, 4'hF, 1'b0, 1'b0};
    tbl[9]  = '{1'b0, 1'b0, 4'hF, 1'b0, 1'b0};
    tbl[10] = '{1'b0, 1'b0, 4'hF, 1'b0, 1'b0};
    tbl[11] = '{1'b0, 1'b0, 4'hF, 1'b0, 1'b0};
    tbl[12] = '{1'b0, 1'b0, 4'hE, 1'b0, 1'b0};
    tbl[13] = '{1'b0, 1'b0, 4'hE, 1'b0, 1'b0};
    tbl[14] = '{1'b0, 1'b0, 4'hC, 1'b0, 1'b0};
    tbl[15] = '{1'b0, 1'b0, 4'hC, 1'b0, 1'b0};
    tbl[16] = '{1'b0, 1'b0, 4'h8, 1'b0, 1'b0};
    tbl[17] = '{1'b0, 1'b0, 4'h8, 1'b0, 1'b0};
    tbl[18] = '{1'b0, 1'b0, 4'h0, 1'b1, 1'b0};
    tbl[19] = '{1'b0, 1'b0, 4'h0, 1'b1, 1'b0};

    // Reset state before any clock edge.
    #1;
    chk_all("reset", 4'hF, 1'b0, 1'b0);
    chk("edge_reset_out",  32'(out2),  32'h1);
    chk("edge_reset_done", 32'(done2), 32'h0);

    // Power-on sequence from the vector table.
    for (int r = 0; r < 20; r++) begin
      arst       = tbl[r].arst;
      sw_rst_req = tbl[r].req;
      tick();
      chk_all($sformatf("pwr_row%0d", r), tbl[r].out, tbl[r].done, tbl[r].ack);
    end

    // arst between edges 12 and 13 of a fresh sequence.
    arst = 1'b1;
    tick();
    arst = 1'b0;
    run_sched("midrel_pre", 10, 1, 12);
    #2 arst = 1'b1;
    #1 chk_all("midrel_async", 4'hF, 1'b0, 1'b0);
    tick();
    chk_all("midrel_held", 4'hF, 1'b0, 1'b0);
    arst = 1'b0;
    run_sched("midrel_post", 10, 1, 17);

    // One-cycle software reset request in RUN.
    sw_rst_req = 1'b1;
    tick();
    chk_all("sw_e0", 4'hF, 1'b0, 1'b1);
    sw_rst_req = 1'b0;
    run_sched("sw", 8, 1, 16);

    // Request held in HOLD is ignored; held across RUN entry it is taken on edge 17.
    arst = 1'b1;
    tick();
    arst = 1'b0;
    for (int k = 1; k <= 17; k++) begin
      sw_rst_req = ((k >= 4) && (k <= 6)) || (k >= 16);
      tick();
      if (k == 17) chk_all("hreq_e17", 4'hF, 1'b0, 1'b1);
      else         chk_all($sformatf("hreq_e%0d", k), exp_out(k, 10), (k >= 16), 1'b0);
    end
    sw_rst_req = 1'b0;
    run_sched("hreq_sw", 8, 1, 14);

    // One-cycle arst glitch in RUN.
    #2 arst = 1'b1;
    #1 chk_all("glitch_async", 4'hF, 1'b0, 1'b0);
    tick();
    chk_all("glitch_held", 4'hF, 1'b0, 1'b0);
    arst = 1'b0;
    run_sched("glitch", 10, 1, 17);

    // NUM_OUT=1, HOLD_CYCLES=1, SYNC_STAGES=3: release and done at edge 4.
    arst2 = 1'b0;
    for (int k = 1; k <= 6; k++) begin
      tick();
      chk($sformatf("edge_out_e%0d", k),  32'(out2),  (k >= 4) ? 32'h0 : 32'h1);
      chk($sformatf("edge_done_e%0d", k), 32'(done2), (k >= 4) ? 32'h1 : 32'h0);
      chk($sformatf("edge_ack_e%0d", k),  32'(ack2),  32'h0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
